// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// datapath widths and a small magnitude helper.
package mult_div_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    // Accumulator: 33-bit upper half (P_hi or R) over a 32-bit lower half (P_lo or Q)
    localparam int ACC_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute-stage ALU (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if;
    import mult_div_pkg::*;

    logic             iStart;
    logic [1:0]       iOp;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iWrHI;
    logic             iWrLO;
    logic [WIDTH-1:0] iWrData;
    logic             oBusy;
    logic             oDone;
    logic             oDivZero;
    logic [WIDTH-1:0] oHI;
    logic [WIDTH-1:0] oLO;

    modport master (
        output iStart, iOp, iA, iB, iWrHI, iWrLO, iWrData,
        input  oBusy, oDone, oDivZero, oHI, oLO
    );

    modport slave (
        input  iStart, iOp, iA, iB, iWrHI, iWrLO, iWrData,
        output oBusy, oDone, oDivZero, oHI, oLO
    );

endinterface

// File: rtl/mult_div_unit_iter_core.sv
// One radix-2 iteration: shift-add multiply step or restoring-division step
// on the shared 65-bit accumulator.
module md_iter_core
    import mult_div_pkg::*;
(
    input  logic             is_div,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [WIDTH-1:0] operand,
    output logic [ACC_W-1:0] acc_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] rem_trial;
    logic             trial_ok;
    logic [WIDTH:0]   rem_new;

    assign mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                   + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});

    // R stays below the divisor, so the shifted remainder fits in 33 bits and
    // bit 33 of the trial difference is the borrow.
    assign rem_shift = acc_in[ACC_W-1:WIDTH-1];
    assign rem_trial = rem_shift - {2'b00, operand};
    assign trial_ok  = ~rem_trial[WIDTH+1];
    assign rem_new   = trial_ok ? rem_trial[WIDTH:0] : rem_shift[WIDTH:0];

    assign acc_out = is_div ? {rem_new, acc_in[WIDTH-2:0], trial_ok}
                            : {1'b0, mul_sum, acc_in[WIDTH-1:1]};

endmodule

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning HI/LO: 32 iterations on the
// magnitudes, then one fix-up cycle that applies signs and writes HI/LO.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic            iCLK,
    input  logic            iRST,
    mult_div_unit_if.slave  bus
);

    state_e           state_reg, state_next;
    logic [4:0]       cnt_reg, cnt_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             div_reg, div_next;
    logic             sa_reg, sa_next;
    logic             sb_reg, sb_next;
    logic             dz_reg, dz_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    logic             start_signed;
    logic             start_div;
    logic [ACC_W-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign start_signed = (bus.iOp == OP_MULT) || (bus.iOp == OP_DIV);
    assign start_div    = (bus.iOp == OP_DIV)  || (bus.iOp == OP_DIVU);

    md_iter_core u_core (
        .is_div  (div_reg),
        .acc_in  (acc_reg),
        .operand (b_reg),
        .acc_out (step_acc)
    );

    assign prod_fix = (sa_reg ^ sb_reg) ? (~acc_reg[2*WIDTH-1:0] + 1'b1) : acc_reg[2*WIDTH-1:0];
    assign quo_fix  = mag(acc_reg[WIDTH-1:0], sa_reg ^ sb_reg);
    // Remainder takes the dividend's sign so the quotient truncates toward zero
    assign rem_fix  = mag(acc_reg[2*WIDTH-1:WIDTH], sa_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        b_next     = b_reg;
        div_next   = div_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        dz_next    = dz_reg;
        done_next  = 1'b0;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            IDLE: begin
                if (bus.iStart) begin
                    div_next = start_div;
                    sa_next  = start_signed & bus.iA[WIDTH-1];
                    sb_next  = start_signed & bus.iB[WIDTH-1];
                    b_next   = mag(bus.iB, start_signed & bus.iB[WIDTH-1]);
                    cnt_next = 5'd0;
                    if (start_div && (bus.iB == '0)) begin
                        // Raw dividend parked in the low half for the HI write in FIX
                        dz_next    = 1'b1;
                        acc_next   = {{(WIDTH+1){1'b0}}, bus.iA};
                        state_next = FIX;
                    end else begin
                        dz_next    = 1'b0;
                        acc_next   = {{(WIDTH+1){1'b0}}, mag(bus.iA, start_signed & bus.iA[WIDTH-1])};
                        state_next = CALC;
                    end
                end else begin
                    if (bus.iWrHI) hi_next = bus.iWrData;
                    if (bus.iWrLO) lo_next = bus.iWrData;
                end
            end
            CALC: begin
                acc_next = step_acc;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'(ITER - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                done_next  = 1'b1;
                cnt_next   = 5'd0;
                state_next = IDLE;
                if (dz_reg) begin
                    hi_next = acc_reg[WIDTH-1:0];
                    lo_next = '1;
                end else if (div_reg) begin
                    hi_next = rem_fix;
                    lo_next = quo_fix;
                end else begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            acc_reg   <= '0;
            b_reg     <= '0;
            div_reg   <= 1'b0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            dz_reg    <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            b_reg     <= b_next;
            div_reg   <= div_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            dz_reg    <= dz_next;
            done_reg  <= done_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign bus.oBusy    = (state_reg != IDLE);
    assign bus.oDone    = done_reg;
    assign bus.oDivZero = dz_reg;
    assign bus.oHI      = hi_reg;
    assign bus.oLO      = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at start,
// compared when oDone pulses.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic iCLK;
    logic iRST;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    exp_t mon_e;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] p;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = p;
            end
            2'b01: {e.hi, e.lo} = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (op == 2'b11) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
        endcase
        return e;
    endfunction

    // Start one op at the next negedge, then wait for oDone counting busy cycles
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit with_wrlo);
        int busy_cnt;
        int n;
        int exp_busy;
        exp_busy = (op[1] && b == 32'd0) ? 1 : 33;
        @(negedge iCLK);
        bus.iStart  = 1'b1;
        bus.iOp     = op;
        bus.iA      = a;
        bus.iB      = b;
        bus.iWrLO   = with_wrlo;
        bus.iWrData = 32'h5A5A_5A5A;
        sb_q.push_back(model(op, a, b));
        @(negedge iCLK);
        bus.iStart = 1'b0;
        bus.iWrLO  = 1'b0;
        busy_cnt = 0;
        n = 0;
        while (!bus.oDone && n < 100) begin
            if (bus.oBusy) busy_cnt++;
            @(negedge iCLK);
            n++;
        end
        check("done_seen", 64'(bus.oDone), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    endtask

    // Result monitor: one line per completed transaction
    always @(negedge iCLK) begin
        if (iRST && bus.oDone) begin
            check("done_vs_busy", 64'(bus.oBusy), 64'd0);
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(bus.oDone), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("done: hi=%h lo=%h divzero=%0d", bus.oHI, bus.oLO, bus.oDivZero);
                check("hi", 64'(bus.oHI), 64'(mon_e.hi));
                check("lo", 64'(bus.oLO), 64'(mon_e.lo));
                check("divzero", 64'(bus.oDivZero), 64'(mon_e.dz));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi_before;
        int          n;
        int          done_cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        iRST        = 1'b0;
        bus.iStart  = 1'b0;
        bus.iOp     = 2'b00;
        bus.iA      = '0;
        bus.iB      = '0;
        bus.iWrHI   = 1'b0;
        bus.iWrLO   = 1'b0;
        bus.iWrData = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_busy", 64'(bus.oBusy), 64'd0);
        check("rst_done", 64'(bus.oDone), 64'd0);
        check("rst_dz", 64'(bus.oDivZero), 64'd0);
        check("rst_hi", 64'(bus.oHI), 64'd0);
        check("rst_lo", 64'(bus.oLO), 64'd0);
        @(negedge iCLK);
        iRST = 1'b1;

        // MTHI/MTLO while idle, then asynchronous reset mid-cycle
        @(negedge iCLK);
        bus.iWrHI = 1'b1; bus.iWrLO = 1'b1; bus.iWrData = 32'h0000_0055;
        @(negedge iCLK);
        bus.iWrHI = 1'b0; bus.iWrLO = 1'b0;
        check("mthi_idle", 64'(bus.oHI), 64'h55);
        @(posedge iCLK);
        #2 iRST = 1'b0;
        #1;
        check("async_rst_hi", 64'(bus.oHI), 64'd0);
        check("async_rst_lo", 64'(bus.oLO), 64'd0);
        check("async_rst_busy", 64'(bus.oBusy), 64'd0);
        @(negedge iCLK);
        iRST = 1'b1;

        do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);           // MULT 7 * -3
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);   // MULTU max*max
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);           // DIV -7 / 2
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   // DIV overflow
        do_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);           // DIVU by zero
        do_op(2'b11, 32'd10, 32'd3, 1'b0);                  // clears divzero
        do_op(2'b10, 32'd5, 32'd0, 1'b0);                   // DIV by zero
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);   // MULT min*min
        do_op(2'b01, 32'd12, 32'd11, 1'b1);                 // start beats MTLO

        // MTLO while idle
        @(negedge iCLK);
        bus.iWrLO = 1'b1; bus.iWrData = 32'h0000_ABCD;
        @(negedge iCLK);
        bus.iWrLO = 1'b0;
        check("mtlo_idle", 64'(bus.oLO), 64'hABCD);

        // Interlocks: start and MTHI during busy are ignored
        hi_before = bus.oHI;
        sb_q.push_back(model(2'b01, 32'd1000, 32'd2000));
        bus.iStart = 1'b1; bus.iOp = 2'b01; bus.iA = 32'd1000; bus.iB = 32'd2000;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        repeat (9) @(negedge iCLK);
        bus.iStart = 1'b1; bus.iOp = 2'b10; bus.iA = 32'd99; bus.iB = 32'd4;
        bus.iWrHI = 1'b1; bus.iWrData = 32'hDEAD_BEEF;
        @(negedge iCLK);
        bus.iStart = 1'b0; bus.iWrHI = 1'b0;
        check("mthi_busy", 64'(bus.oHI), 64'(hi_before));
        n = 11;
        while (!bus.oDone && n < 200) begin
            @(negedge iCLK);
            n++;
        end
        check("interlock_done_cycle", 64'(n), 64'd34);
        @(negedge iCLK);
        check("no_second_op", 64'(bus.oBusy), 64'd0);

        // Reset in cycle 20 of a DIV discards the operation
        bus.iStart = 1'b1; bus.iOp = 2'b10; bus.iA = 32'd1000; bus.iB = 32'd7;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        repeat (19) @(negedge iCLK);
        #2 iRST = 1'b0;
        #1;
        check("midop_rst_busy", 64'(bus.oBusy), 64'd0);
        check("midop_rst_hilo", {32'(bus.oHI), 32'(bus.oLO)}, 64'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (bus.oDone) done_cnt++;
        end
        check("midop_rst_no_done", 64'(done_cnt), 64'd0);
        do_op(2'b11, 32'd100, 32'd9, 1'b0);

        // Random operands over all four ops
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (i % 3 == 1) rb = -rb;
            do_op(2'(i % 4), ra, rb, 1'b0);
        end

        repeat (3) @(negedge iCLK);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential multiply/divide unit that owns the HI/LO register pair and sits beside the ALU in the execute stage. The ALU passes operands and a MULT/MULTU/DIV/DIVU request here on a start pulse. The unit then computes over 33 cycles using a radix-2 shift-add / restoring-division datapath, and presents HI/LO for MFHI/MFLO. The multicycle control FSM stalls on oBusy and resumes on oDone.

## Interface
- WIDTH, 32: operand and HI/LO width; only 32 is supported.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset; asynchronous, active-low (0 = reset).
- iStart  in  1  request pulse; sampled only when oBusy=0.
- iOp  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with iStart.
- iA, iB  in  32  operands (rs, rt); sampled with iStart.
- iWrHI, iWrLO  in  1  MTHI/MTLO write strobes; honoured only when oBusy=0.
- iWrData  in  32  data for MTHI/MTLO.
- oBusy  out  1  operation in progress.
- oDone  out  1  one-cycle pulse; HI/LO updated.
- oDivZero  out  1  last DIV/DIVU had iB=0; held until the next start.
- oHI, oLO  out  32  architectural HI/LO registers.

## Operation
- States:
  - IDLE: on iStart, latch operands and go to CALC, or to FIX if DIV/DIVU with iB=0.
  - CALC: 32 iterations, 5-bit counter 0..31; leave when count=31.
  - FIX: one cycle; write HI/LO, then go to IDLE with oDone asserted.
- Signed ops (MULT, DIV): on start, latch |iA|, |iB| and the sign bits sA, sB. Unsigned ops latch the raw values with signs forced to 0.
- MULT/MULTU, 64-bit product:
  - Accumulator {P_hi, P_lo}, with P_lo initialised to the multiplier.
  - Each iteration adds the multiplicand to P_hi when P_lo[0]=1, then shifts right by 1 through a 33-bit carry.
  - FIX negates the 64-bit product when sA^sB.
- DIV/DIVU, restoring division:
  - 33-bit remainder R and quotient Q; each iteration shifts {R,Q} left by 1, then trial-subtracts the divisor.
  - FIX negates the quotient (LO) when sA^sB and the remainder (HI) when sA.
  - Result: LO = quotient, HI = remainder; quotient truncates toward zero.
- Overflow case, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero: IDLE→FIX directly; HI=iA, LO=0xFFFFFFFF, oDivZero=1.
- iStart while oBusy=1 is ignored; no queueing.
- MTHI/MTLO: when idle, the write lands at that edge. If iStart and iWr* occur in the same cycle, iStart wins and the write is dropped.
- Reset mid-operation: go to IDLE immediately; the result is discarded.

## Timing
- Reset values: state IDLE, oBusy=0, oDone=0, oDivZero=0, oHI=0, oLO=0, counter=0.
- Normal op, with iStart in cycle 0:
  - oBusy=1 in cycles 1–33 (32 CALC + 1 FIX).
  - HI/LO written at the end of cycle 33.
  - oDone=1 and oBusy=0 in cycle 34.
  - A new iStart is accepted in cycle 34.
- Divide by zero: oBusy=1 in cycle 1 only; oDone=1 in cycle 2.
- oHI/oLO are registered outputs; they change only at the FIX edge or on an MTHI/MTLO edge, and are stable otherwise.
- oDone is never high while oBusy=1.

## Structure
- Shared package mult_div_pkg:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum: IDLE, CALC, FIX.
  - ITER=32.
- One sub-module, md_iter_core: combinational single-iteration step.
  - Inputs: mode, {R,Q} or {P_hi,P_lo}, divisor/multiplicand.
  - Output: the next accumulator value.
- The FSM, counter, sign fix-up and HI/LO registers stay in mult_div_unit.

## Test plan
- Reset: drive iRST=0 asynchronously mid-cycle → all outputs 0 immediately. Release iRST, then MULT 7 × −3 → in cycle 34 oDone=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; oBusy high for exactly 33 cycles.
- DIV, signed truncation: −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU by zero: iA=0x1234 → oDone in cycle 2, HI=0x1234, LO=0xFFFFFFFF, oDivZero=1. A following DIVU 10/3 clears oDivZero and gives LO=3, HI=1.
- Busy interlocks:
  - iStart in cycle 10 of a running op → ignored; the result matches the first op.
  - iWrHI during busy → ignored.
  - iWrLO=0xABCD while idle → oLO=0xABCD next cycle.
- Reset in cycle 20 of a DIV → IDLE, oBusy=0, oDone never pulses, HI/LO=0. The next op runs normally.
